// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared region codes, IO register offsets and reset values for the MMIO controller
package mmio_pkg;

    typedef enum logic [2:0] {
        RGN_NONE,
        RGN_DMEM,
        RGN_IMEM,
        RGN_BOTH,
        RGN_BIOS,
        RGN_IO
    } region_e;

    localparam logic [3:0] NIB_DMEM = 4'b0001;
    localparam logic [3:0] NIB_IMEM = 4'b0010;
    localparam logic [3:0] NIB_BOTH = 4'b0011;

    localparam logic [7:0] OFF_UART_CTRL = 8'h00;
    localparam logic [7:0] OFF_UART_RX   = 8'h04;
    localparam logic [7:0] OFF_UART_TX   = 8'h08;
    localparam logic [7:0] OFF_CYC       = 8'h10;
    localparam logic [7:0] OFF_INST      = 8'h14;
    localparam logic [7:0] OFF_CTR_RST   = 8'h18;
    localparam logic [7:0] OFF_EVT_BASE  = 8'h20;

    localparam logic [31:0] RST_RDATA   = 32'h0;
    localparam logic [7:0]  RST_TX_DATA = 8'h0;

    // Memory-side regions only; the IO region is recognised by the caller from addr[31].
    function automatic region_e decode_region(input logic [3:0] nib);
        region_e r;
        casez (nib)
            NIB_DMEM: r = RGN_DMEM;
            NIB_IMEM: r = RGN_IMEM;
            NIB_BOTH: r = RGN_BOTH;
            4'b01??:  r = RGN_BIOS;
            default:  r = RGN_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mmio_counter.sv
// rtl/mmio_counter.sv - wrapping counter with synchronous clear that overrides increment
module mmio_counter #(
    parameter int CTR_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CTR_W-1:0] q
);

    logic [CTR_W-1:0] cnt_q;
    logic [CTR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/mmio_controller.sv
// rtl/mmio_controller.sv - EX-stage address decode, byte write enables and MMIO register file
module mmio_controller
    import mmio_pkg::*;
#(
    parameter int          CTR_W   = 32,
    parameter int          N_EVT   = 2,
    parameter logic [31:0] IO_BASE = 32'h8000_0000,
    localparam int         EW      = (N_EVT > 0) ? N_EVT : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          ex_load,
    input  logic          ex_store,
    input  logic [31:0]   ex_addr,
    input  logic [31:0]   ex_wdata,
    input  logic [3:0]    ex_wmask,
    input  logic          pc_bios,
    input  logic          retire,
    input  logic [EW-1:0] evt,
    output logic [3:0]    dmem_we,
    output logic [3:0]    imem_we,
    output logic          wb_io_sel,
    output logic [31:0]   wb_io_rdata,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready
);

    region_e          rgn;
    logic             is_io;
    logic             wr_en;
    logic             rd_en;
    logic             io_wr;
    logic             io_rd;
    logic [7:0]       io_off;
    logic             tx_accept;
    logic             ctr_clr;
    logic [31:0]      rd_val;
    logic [CTR_W-1:0] cyc_q;
    logic [CTR_W-1:0] inst_q;
    logic [CTR_W-1:0] evt_q [EW];

    logic        wb_io_sel_q,   wb_io_sel_d;
    logic [31:0] wb_io_rdata_q, wb_io_rdata_d;
    logic        tx_valid_q,    tx_valid_d;
    logic [7:0]  tx_data_q,     tx_data_d;

    logic unused_bits;
    assign unused_bits = ^{ex_addr[27:8], ex_addr[1:0], ex_wdata[31:8]};

    // Load and store together is illegal; the store wins so the load side is masked.
    assign is_io  = (ex_addr[31] == IO_BASE[31]);
    assign rgn    = is_io ? RGN_IO : decode_region(ex_addr[31:28]);
    assign wr_en  = rst && ex_store && !stall;
    assign rd_en  = rst && ex_load && !ex_store && !stall;
    assign io_wr  = wr_en && (rgn == RGN_IO);
    assign io_rd  = rd_en && (rgn == RGN_IO);
    assign io_off = {ex_addr[7:2], 2'b00};

    assign tx_accept = io_wr && (io_off == OFF_UART_TX) && tx_ready && !tx_valid_q;
    assign ctr_clr   = io_wr && (io_off == OFF_CTR_RST);
    assign rx_ready  = io_rd && (io_off == OFF_UART_RX) && rx_valid;

    always_comb begin
        dmem_we = 4'b0000;
        imem_we = 4'b0000;
        if (wr_en) begin
            case (rgn)
                RGN_DMEM: dmem_we = ex_wmask;
                RGN_IMEM: imem_we = pc_bios ? ex_wmask : 4'b0000;
                RGN_BOTH: begin
                    dmem_we = ex_wmask;
                    imem_we = pc_bios ? ex_wmask : 4'b0000;
                end
                default: ;
            endcase
        end
    end

    mmio_counter #(.CTR_W(CTR_W)) u_cyc (
        .clk(clk), .rst(rst), .clr(ctr_clr), .inc(1'b1), .q(cyc_q)
    );

    mmio_counter #(.CTR_W(CTR_W)) u_inst (
        .clk(clk), .rst(rst), .clr(ctr_clr), .inc(retire), .q(inst_q)
    );

    generate
        if (N_EVT > 0) begin : g_evt
            for (genvar i = 0; i < N_EVT; i++) begin : g_ctr
                mmio_counter #(.CTR_W(CTR_W)) u_evt (
                    .clk(clk), .rst(rst), .clr(ctr_clr), .inc(evt[i]), .q(evt_q[i])
                );
            end
        end else begin : g_no_evt
            logic unused_evt;
            assign unused_evt = evt[0];
            assign evt_q[0]   = '0;
        end
    endgenerate

    always_comb begin
        rd_val = 32'h0;
        case (io_off)
            OFF_UART_CTRL: rd_val = {30'b0, rx_valid, tx_ready};
            OFF_UART_RX:   rd_val = {24'b0, rx_data};
            OFF_CYC:       rd_val = 32'(cyc_q);
            OFF_INST:      rd_val = 32'(inst_q);
            default: begin
                for (int i = 0; i < N_EVT; i++) begin
                    if (io_off == OFF_EVT_BASE + 8'(4 * i)) begin
                        rd_val = 32'(evt_q[i]);
                    end
                end
            end
        endcase
    end

    always_comb begin
        wb_io_sel_d   = wb_io_sel_q;
        wb_io_rdata_d = wb_io_rdata_q;
        tx_valid_d    = tx_valid_q;
        tx_data_d     = tx_data_q;
        if (!stall) begin
            wb_io_sel_d = io_rd;
            if (io_rd) begin
                wb_io_rdata_d = rd_val;
            end
        end
        // A handshake completing this cycle frees the slot only from the next cycle on.
        if (tx_valid_q && tx_ready) begin
            tx_valid_d = 1'b0;
        end else if (tx_accept) begin
            tx_valid_d = 1'b1;
            tx_data_d  = ex_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_io_sel_q   <= 1'b0;
            wb_io_rdata_q <= RST_RDATA;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= RST_TX_DATA;
        end else begin
            wb_io_sel_q   <= wb_io_sel_d;
            wb_io_rdata_q <= wb_io_rdata_d;
            tx_valid_q    <= tx_valid_d;
            tx_data_q     <= tx_data_d;
        end
    end

    assign wb_io_sel   = wb_io_sel_q;
    assign wb_io_rdata = wb_io_rdata_q;
    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;

endmodule

// File: tb/tb_mmio_controller.sv
// tb/tb_mmio_controller.sv - scoreboard bench for mmio_controller with a behavioural reference model
module tb_mmio_controller;

    localparam int CTR_W = 4;
    localparam int N_EVT = 2;
    localparam int MOD   = 1 << CTR_W;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        ex_load = 1'b0;
    logic        ex_store = 1'b0;
    logic [31:0] ex_addr = '0;
    logic [31:0] ex_wdata = '0;
    logic [3:0]  ex_wmask = '0;
    logic        pc_bios = 1'b0;
    logic        retire = 1'b0;
    logic [1:0]  evt = '0;
    logic [3:0]  dmem_we;
    logic [3:0]  imem_we;
    logic        wb_io_sel;
    logic [31:0] wb_io_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;

    mmio_controller #(.CTR_W(CTR_W), .N_EVT(N_EVT), .IO_BASE(32'h8000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .ex_load(ex_load), .ex_store(ex_store),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_wmask(ex_wmask), .pc_bios(pc_bios),
        .retire(retire), .evt(evt), .dmem_we(dmem_we), .imem_we(imem_we),
        .wb_io_sel(wb_io_sel), .wb_io_rdata(wb_io_rdata), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          sel;
        logic [31:0] rd;
        bit          txv;
        logic [7:0]  txd;
    } exp_t;
    exp_t exp_q[$];

    // Reference state: counters as plain integers, WB and UART TX as abstract values.
    int          m_cyc = 0, m_inst = 0;
    int          m_ev[N_EVT];
    bit          m_sel = 0, m_txv = 0;
    logic [31:0] m_rd = '0;
    logic [7:0]  m_txd = '0;

    bit          s_rst, s_stall, s_load, s_store, s_bios, s_retire, s_txr, s_rxv;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_mask;
    logic [1:0]  s_evt;
    logic [7:0]  s_rxd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] off);
        if (off == 8'h00) return {30'b0, s_rxv, s_txr};
        if (off == 8'h04) return {24'b0, s_rxd};
        if (off == 8'h10) return 32'(m_cyc);
        if (off == 8'h14) return 32'(m_inst);
        if (off >= 8'h20 && off < 8'h20 + 8'(4 * N_EVT)) return 32'(m_ev[(off - 8'h20) / 4]);
        return 32'h0;
    endfunction

    task automatic idle();
        s_rst = 1; s_stall = 0; s_load = 0; s_store = 0; s_bios = 0; s_retire = 0;
        s_txr = 0; s_rxv = 0; s_addr = '0; s_wdata = '0; s_mask = '0; s_evt = '0; s_rxd = '0;
    endtask

    task automatic cycle();
        exp_t e;
        bit wr, rd, io, clr;
        logic [7:0] off;
        logic [3:0] nib, edm, eim;
        logic [31:0] rv;
        @(posedge clk);
        #1;
        rst = s_rst; stall = s_stall; ex_load = s_load; ex_store = s_store; ex_addr = s_addr;
        ex_wdata = s_wdata; ex_wmask = s_mask; pc_bios = s_bios; retire = s_retire; evt = s_evt;
        tx_ready = s_txr; rx_valid = s_rxv; rx_data = s_rxd;
        #1;
        wr  = s_rst && s_store && !s_stall;
        rd  = s_rst && s_load && !s_store && !s_stall;
        io  = s_addr[31];
        off = s_addr[7:0] & 8'hFC;
        nib = s_addr[31:28];
        edm = '0;
        eim = '0;
        if (wr && (nib == 4'h1 || nib == 4'h3)) edm = s_mask;
        if (wr && s_bios && (nib == 4'h2 || nib == 4'h3)) eim = s_mask;
        chk("dmem_we", {28'b0, dmem_we}, {28'b0, edm});
        chk("imem_we", {28'b0, imem_we}, {28'b0, eim});
        chk("rx_ready", {31'b0, rx_ready}, {31'b0, rd && io && off == 8'h04 && s_rxv});
        rv = model_read(off);
        if (!s_rst) begin
            m_cyc = 0; m_inst = 0; m_sel = 0; m_rd = '0; m_txv = 0;
            foreach (m_ev[i]) m_ev[i] = 0;
        end else begin
            clr = wr && io && off == 8'h18;
            if (m_txv && s_txr) m_txv = 0;
            else if (wr && io && off == 8'h08 && s_txr && !m_txv) begin
                m_txv = 1;
                m_txd = s_wdata[7:0];
            end
            if (!s_stall) begin
                m_sel = rd && io;
                if (m_sel) m_rd = rv;
            end
            m_cyc  = clr ? 0 : (m_cyc + 1) % MOD;
            m_inst = clr ? 0 : (m_inst + int'(s_retire)) % MOD;
            foreach (m_ev[i]) m_ev[i] = clr ? 0 : (m_ev[i] + int'(s_evt[i])) % MOD;
        end
        e.sel = m_sel; e.rd = m_rd; e.txv = m_txv; e.txd = m_txd;
        exp_q.push_back(e);
    endtask

    // Monitor: each cycle compares the registered outputs against the entry queued one cycle earlier.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #4;
            if (exp_q.size() >= 2) begin
                e = exp_q.pop_front();
                chk("wb_io_sel", {31'b0, wb_io_sel}, {31'b0, e.sel});
                chk("wb_io_rdata", wb_io_rdata, e.rd);
                chk("tx_valid", {31'b0, tx_valid}, {31'b0, e.txv});
                if (e.txv) chk("tx_data", {24'b0, tx_data}, {24'b0, e.txd});
            end
        end
    end

    localparam logic [31:0] ADDRS [16] = '{
        32'h1000_0040, 32'h3000_0010, 32'h2000_0004, 32'h4000_0000,
        32'h0000_0000, 32'h8000_0000, 32'h8000_0004, 32'h8000_0008,
        32'h8000_0010, 32'h8000_0014, 32'h8000_0018, 32'h8000_0020,
        32'h8000_0024, 32'h8000_0028, 32'h8000_000C, 32'hF000_0010
    };

    initial begin
        logic [31:0] addrs [16];
        int op;
        addrs = ADDRS;
        foreach (m_ev[i]) m_ev[i] = 0;

        idle(); s_rst = 0;
        repeat (3) cycle();
        idle();
        repeat (3) cycle();
        s_load = 1; s_addr = 32'h8000_0010; cycle();

        idle(); s_txr = 1; s_store = 1; s_addr = 32'h8000_0008; s_wdata = 32'h0000_00AB; cycle();
        idle(); s_txr = 0; cycle();
        s_store = 1; s_addr = 32'h8000_0008; s_wdata = 32'h0000_00CD; cycle();
        idle(); cycle();
        s_txr = 1; cycle();
        idle(); cycle();

        idle(); s_rxv = 1; s_rxd = 8'h5A; s_load = 1; s_addr = 32'h8000_0004; cycle();
        idle(); s_rxd = 8'h33; s_load = 1; s_addr = 32'h8000_0004; cycle();

        idle(); s_store = 1; s_addr = 32'h3000_0010; s_mask = 4'b0011; s_bios = 1; cycle();
        s_bios = 0; cycle();
        s_addr = 32'h2000_0010; s_bios = 1; cycle();
        s_addr = 32'h5000_0010; cycle();

        idle(); s_rst = 0; cycle();
        idle(); repeat (17) cycle();
        s_load = 1; s_addr = 32'h8000_0010; cycle();
        idle(); s_retire = 1; repeat (3) cycle();
        s_store = 1; s_addr = 32'h8000_0018; cycle();
        idle(); s_load = 1; s_addr = 32'h8000_0014; cycle();

        idle(); s_evt = 2'b10; repeat (5) cycle();
        idle(); s_load = 1; s_addr = 32'h8000_0024; s_stall = 1; repeat (2) cycle();
        s_stall = 0; cycle();
        idle(); cycle();

        for (int n = 0; n < 400; n++) begin
            idle();
            s_rst    = ($urandom_range(0, 49) != 0);
            s_stall  = ($urandom_range(0, 4) == 0);
            op       = $urandom_range(0, 2);
            s_load   = (op == 1);
            s_store  = (op == 2);
            s_addr   = addrs[$urandom_range(0, 15)];
            s_wdata  = $urandom;
            s_mask   = 4'($urandom);
            s_bios   = 1'($urandom);
            s_retire = 1'($urandom);
            s_evt    = 2'($urandom);
            s_txr    = 1'($urandom);
            s_rxv    = 1'($urandom);
            s_rxd    = 8'($urandom);
            cycle();
        end

        idle();
        repeat (3) cycle();
        @(posedge clk);
        #6;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
